// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle for serial_subtractor.
// Port ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] c;
    logic             bout;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input c, bout, busy, done, ovf);
    modport slave  (input start, a, b, bin, output c, bout, busy, done, ovf);
`else
    modport master (output start, a, b, bin, input c, bout, busy, done);
    modport slave  (input start, a, b, bin, output c, bout, busy, done);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout, c} = a - b - bin, one full-subtractor cell, LSB first.
// Optional signed-overflow flag ovf enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] c_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_r;
`endif

    logic             a_bit_s;
    logic             b_bit_s;
    logic             diff_bit_s;
    logic             br_next_s;

    // Full-subtractor cell working on the current LSB of the shifted operands.
    always_comb begin
        a_bit_s    = a_r[0];
        b_bit_s    = b_r[0];
        diff_bit_s = a_bit_s ^ b_bit_s ^ br_r;
        br_next_s  = (~a_bit_s & b_bit_s) | (~(a_bit_s ^ b_bit_s) & br_r);
    end

    // Control FSM, operand shifters and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            diff_r  <= '0;
            br_r    <= 1'b0;
            cnt_r   <= '0;
            c_r     <= '0;
            bout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        br_r    <= bus.bin;
                        diff_r  <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    a_r    <= a_r >> 1;
                    b_r    <= b_r >> 1;
                    br_r   <= br_next_s;
                    diff_r <= {diff_bit_s, diff_r[WIDTH-1:1]};
                    if (cnt_r == LAST_BIT) begin
                        // Result registers change only here, so c never shows a partial value.
                        c_r     <= {diff_bit_s, diff_r[WIDTH-1:1]};
                        bout_r  <= br_next_s;
`ifdef SERIAL_SUB_OVF_EN
                        // Signed overflow: borrow into the sign bit differs from borrow out of it.
                        ovf_r   <= br_r ^ br_next_s;
`endif
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.c    = c_r;
    assign bus.bout = bout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] c;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] ec, input logic eb, input logic eo);
        check({tag, " c"}, 32'(bus.c), 32'(ec));
        check({tag, " bout"}, 32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unused ovf expectation");
`endif
    endtask

    // One complete operation: start pulse, latency, result, done pulse width, hold.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                          input logic [7:0] ec, input logic eb, input logic eo, input string tag);
        int cyc;
        @(negedge clk);
        bus.a = va; bus.b = vb; bus.bin = vbin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        bus.a = ~va; bus.b = ~vb; bus.bin = ~vbin;
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd8);
        check_result(tag, ec, eb, eo);
        @(posedge clk); #1;
        check({tag, " done_width"}, 32'(bus.done), 32'd0);
        check({tag, " hold_c"}, 32'(bus.c), 32'(ec));
    endtask

    initial begin
        int dones;
        int done_at;
        int last;
        int nd;
        int low;
        checks = 0;
        errors = 0;
        vecs[0]  = '{8'd100, 8'd30,  1'b0, 8'd70,  1'b0, 1'b0};
        vecs[1]  = '{8'd30,  8'd100, 1'b0, 8'd186, 1'b1, 1'b0};
        vecs[2]  = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 1'b0};
        vecs[3]  = '{8'd128, 8'd1,   1'b0, 8'd127, 1'b0, 1'b1};
        vecs[4]  = '{8'd127, 8'd255, 1'b0, 8'd128, 1'b1, 1'b1};
        vecs[5]  = '{8'd200, 8'd50,  1'b0, 8'd150, 1'b0, 1'b0};
        vecs[6]  = '{8'd5,   8'd3,   1'b0, 8'd2,   1'b0, 1'b0};
        vecs[7]  = '{8'd9,   8'd4,   1'b0, 8'd5,   1'b0, 1'b0};
        vecs[8]  = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0};
        vecs[9]  = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1, 1'b0};
        vecs[10] = '{8'd10,  8'd10,  1'b1, 8'd255, 1'b1, 1'b0};
        vecs[11] = '{8'd127, 8'd0,   1'b1, 8'd126, 1'b0, 1'b0};
        vecs[12] = '{8'd128, 8'd0,   1'b1, 8'd127, 1'b0, 1'b1};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = 8'd0; bus.b = 8'd0; bus.bin = 1'b0;
        #12;
        check("reset c", 32'(bus.c), 32'd0);
        check("reset bout", 32'(bus.bout), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].c, vecs[i].bout, vecs[i].ovf,
                   $sformatf("vec%0d", i));
        end

        // Start re-pulsed during RUN must be ignored.
        @(negedge clk);
        bus.a = 8'd200; bus.b = 8'd50; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0;
        done_at = -1;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin bus.a = 8'd1; bus.b = 8'd1; bus.start = 1'b1; end
            if (i == 3) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                done_at = i;
                check_result("repulse", 8'd150, 1'b0, 1'b0);
            end
        end
        check("repulse dones", 32'(dones), 32'd1);
        check("repulse done_at", 32'(done_at), 32'd7);

        // Reset during the 4th RUN cycle aborts with no done pulse.
        @(negedge clk);
        bus.a = 8'd200; bus.b = 8'd50; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort c", 32'(bus.c), 32'd0);
        check("abort bout", 32'(bus.bout), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        low = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
            if (bus.busy) low++;
        end
        check("abort no_done", 32'(dones), 32'd0);
        check("abort stays_idle", 32'(low), 32'd0);
        run_op(8'd5, 8'd3, 1'b0, 8'd2, 1'b0, 1'b0, "after_abort");

        // Start held high: one operation every W+2 cycles.
        @(negedge clk);
        bus.a = 8'd9; bus.b = 8'd4; bus.bin = 1'b0; bus.start = 1'b1;
        last = -1;
        nd = 0;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (nd > 0) check("held period", 32'(i - last), 32'd10);
                check("held c", 32'(bus.c), 32'd5);
                check("held busy_in_done", 32'(bus.busy), 32'd0);
                last = i;
                nd++;
            end
            if (i >= 8 && i <= 37 && !bus.busy) low++;
        end
        bus.start = 1'b0;
        check("held done_count", 32'(nd), 32'd4);
        check("held busy_low", 32'(low), 32'd6);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end
endmodule
